weight_stream_reader: RTL and testbench

- Read-side initiator for one single-port weight BRAM (DEPTH x DATA_W, negedge-read, 1-cycle read latency seen from the posedge domain).
- On START, sequences addresses 0..DEPTH-1 and captures DO.
- Presents the weights as a valid/ready stream to the neuron MAC.
- Internal 2-entry buffer absorbs MAC backpressure without losing in-flight BRAM reads.

---
 rtl/weight_stream_reader.sv | 207 ++++++++++++++++++++
 tb/tb_weight_stream_reader.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_reader.sv
// Streams DEPTH weights from a negedge-read BRAM onto a valid/ready link via a 2-entry buffer.
// Define WEIGHT_LOAD_EN to add the LD_* fill path that writes the BRAM from a stream.
module weight_stream_reader #(
  parameter int unsigned DEPTH  = 28,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic [ADDR_W-1:0] ADDR,
  output logic              EN,
  output logic              WE,
  output logic [DATA_W-1:0] DI,
  input  logic [DATA_W-1:0] DO,
  output logic [DATA_W-1:0] W_DATA,
  output logic              W_VALID,
  input  logic              W_READY,
  output logic              W_LAST,
  output logic [ADDR_W-1:0] W_INDEX
`ifdef WEIGHT_LOAD_EN
  ,
  input  logic              LD_VALID,
  input  logic [DATA_W-1:0] LD_DATA,
  output logic              LD_READY
`endif
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_FLUSH   = 3'd2;
  localparam logic [2:0] S_DONE_ST = 3'd3;
`ifdef WEIGHT_LOAD_EN
  localparam logic [2:0] S_LOAD    = 3'd4;
`endif

  // One extra counter bit so the issue count can reach DEPTH even when DEPTH == 2**ADDR_W.
  localparam int unsigned       CNT_W     = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(DEPTH - 1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_d;
  logic [CNT_W-1:0]  r_issued;
  logic [CNT_W-1:0]  w_issued_d;
  logic              r_inflight;
  logic              r_en;
  logic [ADDR_W-1:0] r_addr;

  logic [DATA_W-1:0] r_buf_data [2];
  logic [ADDR_W-1:0] r_buf_idx  [2];
  logic              r_buf_last [2];
  logic              r_rd_ptr;
  logic              r_wr_ptr;
  logic [1:0]        r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_head_last;
  logic [2:0]        w_occ;
  logic              w_has_credit;
  logic              w_issue;
  logic              w_load_wr;
  logic              w_fire;

  assign W_VALID     = (r_count != 2'd0);
  assign W_DATA      = r_buf_data[r_rd_ptr];
  assign W_INDEX     = r_buf_idx[r_rd_ptr];
  assign w_head_last = r_buf_last[r_rd_ptr];
  assign W_LAST      = W_VALID && w_head_last;

  assign w_pop  = W_VALID && W_READY;
  assign w_push = r_inflight;

  // A slot freed by this cycle's pop may be reused by the read issued now.
  assign w_occ        = {1'b0, r_count} + {2'b00, r_inflight};
  assign w_has_credit = (w_occ < (3'd2 + {2'b00, w_pop}));
  assign w_fire       = w_issue | w_load_wr;

  assign BUSY = (r_state != S_IDLE);
  assign DONE = (r_state == S_DONE_ST);
  assign ADDR = r_addr;
  assign EN   = r_en;

  always_comb begin
    w_state_d  = r_state;
    w_issued_d = r_issued;
    w_issue    = 1'b0;
    w_load_wr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state_d = S_RUN;
        end
`ifdef WEIGHT_LOAD_EN
        else if (LD_VALID) begin
          w_load_wr  = 1'b1;
          w_issued_d = r_issued + CNT_W'(1);
          w_state_d  = (r_issued == CNT_LAST) ? S_DONE_ST : S_LOAD;
        end
`endif
      end
      S_RUN: begin
        w_issue = w_has_credit && (r_issued < CNT_DEPTH);
        if (w_issue) begin
          w_issued_d = r_issued + CNT_W'(1);
          if (r_issued == CNT_LAST) begin
            w_state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (w_pop && w_head_last) begin
          w_state_d = S_DONE_ST;
        end
      end
      S_DONE_ST: begin
        w_issued_d = '0;
        w_state_d  = S_IDLE;
      end
`ifdef WEIGHT_LOAD_EN
      S_LOAD: begin
        if (LD_VALID) begin
          w_load_wr  = 1'b1;
          w_issued_d = r_issued + CNT_W'(1);
          if (r_issued == CNT_LAST) begin
            w_state_d = S_DONE_ST;
          end
        end
      end
`endif
      default: begin
        w_state_d  = S_IDLE;
        w_issued_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_issued   <= '0;
      r_inflight <= 1'b0;
      r_en       <= 1'b0;
      r_addr     <= '0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_buf_data[i] <= '0;
        r_buf_idx[i]  <= '0;
        r_buf_last[i] <= 1'b0;
      end
    end else begin
      r_state    <= w_state_d;
      r_issued   <= w_issued_d;
      r_inflight <= w_issue;
      r_en       <= w_fire;
      if (w_fire) begin
        r_addr <= r_issued[ADDR_W-1:0];
      end

      // ADDR still holds the address of the read now landing on DO.
      if (w_push) begin
        r_buf_data[r_wr_ptr] <= DO;
        r_buf_idx[r_wr_ptr]  <= r_addr;
        r_buf_last[r_wr_ptr] <= (r_addr == IDX_LAST);
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef WEIGHT_LOAD_EN
  logic              r_we;
  logic [DATA_W-1:0] r_di;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_we <= 1'b0;
      r_di <= '0;
    end else begin
      r_we <= w_load_wr;
      r_di <= w_load_wr ? LD_DATA : '0;
    end
  end

  assign WE       = r_we;
  assign DI       = r_di;
  assign LD_READY = ((r_state == S_IDLE) && !START) || (r_state == S_LOAD);
`else
  assign WE = 1'b0;
  assign DI = '0;
`endif

endmodule

// File: tb/tb_weight_stream_reader.sv
// Randomized bench for weight_stream_reader: BRAM model, ordered-stream reference and scoreboard.
module tb_weight_stream_reader;

  localparam int DEPTH  = 28;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  logic              CLK;
  logic              RST;
  logic              START;
  logic              BUSY;
  logic              DONE;
  logic [ADDR_W-1:0] ADDR;
  logic              EN;
  logic              WE;
  logic [DATA_W-1:0] DI;
  logic [DATA_W-1:0] DO;
  logic [DATA_W-1:0] W_DATA;
  logic              W_VALID;
  logic              W_READY;
  logic              W_LAST;
  logic [ADDR_W-1:0] W_INDEX;
`ifdef WEIGHT_LOAD_EN
  logic              LD_VALID;
  logic [DATA_W-1:0] LD_DATA;
  logic              LD_READY;
`endif

  weight_stream_reader #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .START   (START),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .ADDR    (ADDR),
    .EN      (EN),
    .WE      (WE),
    .DI      (DI),
    .DO      (DO),
    .W_DATA  (W_DATA),
    .W_VALID (W_VALID),
    .W_READY (W_READY),
    .W_LAST  (W_LAST),
    .W_INDEX (W_INDEX)
`ifdef WEIGHT_LOAD_EN
    ,
    .LD_VALID (LD_VALID),
    .LD_DATA  (LD_DATA),
    .LD_READY (LD_READY)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  logic [DATA_W-1:0] bram    [DEPTH];
  logic [DATA_W-1:0] exp_mem [DEPTH];
  logic              preload_req = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor-owned counters; the sequencer only snapshots them as per-run bases.
  int cyc = 0, reads = 0, xfers = 0, writes = 0, done_cnt = 0;
  int done_cyc = 0, last_xfer_cyc = 0, first_en_cyc = 0, mon_k = 0;
  logic                     hold_pend = 1'b0;
  logic [DATA_W+ADDR_W+1:0] hold_val  = '0;
  int base_reads = 0, base_xfers = 0, base_writes = 0, base_done = 0;
  int rdy_mode = 3, pat_i = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // BRAM model: sampled on the falling edge, data visible at the next rising edge.
  always @(negedge CLK) begin
    if (preload_req) begin
      for (int i = 0; i < DEPTH; i++) bram[i] <= exp_mem[i];
    end else if (EN === 1'b1) begin
      if (WE === 1'b1) begin
        if (int'(ADDR) < DEPTH) bram[ADDR] <= DI;
      end else begin
        DO <= (int'(ADDR) < DEPTH) ? bram[ADDR] : 16'hDEAD;
      end
    end
  end

  always @(negedge CLK) begin
    cyc++;
    if (EN === 1'b1) begin
      if (WE === 1'b1) begin
        mon_k = writes - base_writes;
        check("wr_extra", mon_k < DEPTH, 1);
        check("wr_addr", ADDR, mon_k);
        check("wr_data", DI, exp_mem[mon_k % DEPTH]);
        writes++;
      end else begin
        mon_k = reads - base_reads;
        check("rd_extra", mon_k < DEPTH, 1);
        check("rd_addr", ADDR, mon_k);
        check("rd_room", (mon_k + 1 - (xfers - base_xfers)) <= 2, 1);
        if (mon_k == 0) first_en_cyc = cyc;
        reads++;
      end
    end
    if (RST === 1'b1) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) check("stall_hold", {W_VALID, W_DATA, W_INDEX, W_LAST}, hold_val);
      hold_pend = (W_VALID === 1'b1) && (W_READY === 1'b0);
      hold_val  = {W_VALID, W_DATA, W_INDEX, W_LAST};
    end
    if (W_VALID === 1'b1 && W_READY === 1'b1) begin
      mon_k = xfers - base_xfers;
      check("xfer_extra", mon_k < DEPTH, 1);
      check("xfer_data", W_DATA, exp_mem[mon_k % DEPTH]);
      check("xfer_index", W_INDEX, mon_k);
      check("xfer_last", W_LAST, mon_k == DEPTH - 1);
      xfers++;
      last_xfer_cyc = cyc;
    end
    if (DONE === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic set_ready();
    case (rdy_mode)
      0: W_READY = 1'b1;
      1: begin
        W_READY = (pat_i == 0) || (pat_i == 3);
        pat_i   = (pat_i + 1) % 4;
      end
      2: W_READY = 1'($urandom_range(0, 1));
      default: W_READY = 1'b0;
    endcase
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    set_ready();
  endtask

  task automatic begin_run();
    base_reads  = reads;
    base_xfers  = xfers;
    base_writes = writes;
    base_done   = done_cnt;
  endtask

  task automatic preload();
    preload_req = 1'b1;
    tick();
    preload_req = 1'b0;
  endtask

  // stall: cycles of W_READY=0 after START; restart_at/abort_at: transfer count or -1.
  task automatic run_stream(input int mode, input int stall, input int restart_at,
                            input int abort_at);
    int n;
    begin_run();
    pat_i    = 0;
    rdy_mode = (stall > 0) ? 3 : mode;
    set_ready();
    START = 1'b1;
    tick();
    START = 1'b0;
    check("lat0_en", EN, 0);
    check("lat0_busy", BUSY, 1);
    check("lat0_valid", W_VALID, 0);
    tick();
    check("lat1_en", EN, 1);
    check("lat1_addr", ADDR, 0);
    check("lat1_valid", W_VALID, 0);
    tick();
    check("lat2_valid", W_VALID, 1);
    check("lat2_data", W_DATA, exp_mem[0]);
    check("lat2_index", W_INDEX, 0);
    if (stall > 0) begin
      for (int k = 2; k < stall; k++) tick();
      check("stall_reads", reads - base_reads, 2);
      check("stall_en", EN, 0);
      check("stall_data", W_DATA, exp_mem[0]);
      check("stall_index", W_INDEX, 0);
      rdy_mode = mode;
      set_ready();
    end
    n = 0;
    while ((done_cnt == base_done) && (n < 400) &&
           !((abort_at >= 0) && ((xfers - base_xfers) >= abort_at))) begin
      START = (restart_at >= 0) && ((xfers - base_xfers) == restart_at);
      tick();
      n++;
    end
    START = 1'b0;
    if (abort_at >= 0) begin
      check("abort_reached", (xfers - base_xfers) >= abort_at, 1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check("abort_valid", W_VALID, 0);
      check("abort_busy", BUSY, 0);
      check("abort_en", EN, 0);
      for (int k = 0; k < 4; k++) tick();
      check("abort_no_done", done_cnt - base_done, 0);
      check("abort_idle_valid", W_VALID, 0);
    end else begin
      check("run_done", done_cnt - base_done, 1);
      check("run_xfers", xfers - base_xfers, DEPTH);
      check("run_reads", reads - base_reads, DEPTH);
      check("done_lat", done_cyc - last_xfer_cyc, 1);
      if (mode == 0 && stall == 0 && restart_at < 0) begin
        check("run_span", last_xfer_cyc - first_en_cyc, DEPTH);
      end
      tick();
      tick();
      check("idle_busy", BUSY, 0);
      check("single_done", done_cnt - base_done, 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "time limit");
  end

  initial begin
    RST     = 1'b1;
    START   = 1'b0;
    W_READY = 1'b0;
`ifdef WEIGHT_LOAD_EN
    LD_VALID = 1'b0;
    LD_DATA  = '0;
`endif
    tick();
    tick();
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_en", EN, 0);
    check("rst_we", WE, 0);
    check("rst_di", DI, 0);
    check("rst_addr", ADDR, 0);
    check("rst_valid", W_VALID, 0);
    check("rst_data", W_DATA, 0);
    check("rst_last", W_LAST, 0);
    check("rst_index", W_INDEX, 0);
    RST = 1'b0;

    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 16'(16'h0100 + i);
    preload();
    run_stream(0, 0, -1, -1);
    run_stream(1, 0, -1, -1);
    run_stream(0, 10, -1, -1);
    run_stream(1, 0, 5, -1);
    run_stream(0, 0, -1, 12);
    run_stream(0, 0, -1, -1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = 16'($urandom);
      preload();
      run_stream(2, ($urandom_range(0, 1) == 1) ? int'($urandom_range(3, 12)) : 0, -1, -1);
    end

`ifdef WEIGHT_LOAD_EN
    begin
      int k, c, n;
      logic acc;
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = 16'(16'hA000 + i);
      begin_run();
      k = 0;
      c = 0;
      n = 0;
      while ((done_cnt == base_done) && (n < 400)) begin
        LD_VALID = ((c % 3) != 2);
        LD_DATA  = 16'(16'hA000 + k);
        acc      = LD_VALID && LD_READY;
        tick();
        if (acc) k++;
        c++;
        n++;
      end
      LD_VALID = 1'b0;
      check("ld_writes", writes - base_writes, DEPTH);
      check("ld_accepted", k, DEPTH);
      check("ld_done", done_cnt - base_done, 1);
      tick();
      check("ld_idle", BUSY, 0);
      run_stream(0, 0, -1, -1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
